// File: rtl/univ_shift_reg_pkg.sv
// -----------------------------------------------------------------------------
// shift_pkg
// Shared definitions for the universal shift register slice.
//   MODE_*  : 2-bit operation select encodings driven on `mode`
//   dir_t   : direction state of the word framer
// -----------------------------------------------------------------------------
package shift_pkg;

    localparam logic [1:0] MODE_HOLD = 2'b00;
    localparam logic [1:0] MODE_SHR  = 2'b01;
    localparam logic [1:0] MODE_SHL  = 2'b10;
    localparam logic [1:0] MODE_LOAD = 2'b11;

    typedef enum logic [1:0] {
        DIR_IDLE,
        DIR_RIGHT,
        DIR_LEFT
    } dir_t;

endpackage : shift_pkg

// File: rtl/univ_shift_reg_if.sv
// -----------------------------------------------------------------------------
// univ_shift_reg_if
// Bundles the control, serial and parallel signals of univ_shift_reg.
//   en, mode          : clock enable and operation select
//   ser_in_r/ser_in_l : serial inputs for right / left shifts
//   par_in            : parallel load data
//   par_out           : register contents
//   ser_out_r/_l      : LSB / MSB of the register
//   word_valid        : one-cycle pulse after a full word has been shifted
// master drives the controls and data inputs; slave is the shift register.
// -----------------------------------------------------------------------------
interface univ_shift_reg_if #(
    parameter int WIDTH = 4
);

    logic             en;
    logic [1:0]       mode;
    logic             ser_in_r;
    logic             ser_in_l;
    logic [WIDTH-1:0] par_in;
    logic [WIDTH-1:0] par_out;
    logic             ser_out_r;
    logic             ser_out_l;
    logic             word_valid;

    modport master (
        output en, mode, ser_in_r, ser_in_l, par_in,
        input  par_out, ser_out_r, ser_out_l, word_valid
    );

    modport slave (
        input  en, mode, ser_in_r, ser_in_l, par_in,
        output par_out, ser_out_r, ser_out_l, word_valid
    );

endinterface : univ_shift_reg_if

// File: rtl/univ_shift_reg_framer.sv
// -----------------------------------------------------------------------------
// usr_word_framer
// Tracks the current shift direction and how many bits of the current word
// have been shifted; pulses word_valid for one cycle after WIDTH consecutive
// same-direction shifts.
//   clk        : rising-edge clock
//   rst_n      : asynchronous active-low reset
//   en         : clock enable, freezes state and counter when low
//   mode       : operation select (HOLD/SHR/SHL/LOAD)
//   word_valid : registered one-cycle word-complete pulse
// -----------------------------------------------------------------------------
module usr_word_framer
    import shift_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [1:0] mode,
    output logic       word_valid
);

    localparam int             CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    dir_t             state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic             wv_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= DIR_IDLE;
            cnt        <= '0;
            word_valid <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            word_valid <= wv_n;
        end
    end

    // A direction change starts a new word with the switching shift as its
    // first bit, so it takes priority over the wrap check.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        wv_n    = 1'b0;
        if (en) begin
            case (mode)
                MODE_LOAD: begin
                    state_n = DIR_IDLE;
                    cnt_n   = '0;
                end
                MODE_SHR: begin
                    state_n = DIR_RIGHT;
                    if (state == DIR_LEFT) begin
                        cnt_n = CNT_ONE;
                    end else if (cnt == CNT_LAST) begin
                        cnt_n = '0;
                        wv_n  = 1'b1;
                    end else begin
                        cnt_n = cnt + CNT_ONE;
                    end
                end
                MODE_SHL: begin
                    state_n = DIR_LEFT;
                    if (state == DIR_RIGHT) begin
                        cnt_n = CNT_ONE;
                    end else if (cnt == CNT_LAST) begin
                        cnt_n = '0;
                        wv_n  = 1'b1;
                    end else begin
                        cnt_n = cnt + CNT_ONE;
                    end
                end
                default: begin
                    state_n = state;
                    cnt_n   = cnt;
                end
            endcase
        end
    end

endmodule : usr_word_framer

// File: rtl/univ_shift_reg.sv
// -----------------------------------------------------------------------------
// univ_shift_reg
// WIDTH-bit universal shift register: hold, shift-right, shift-left and
// parallel load, with per-direction serial outputs and a word-complete pulse.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : univ_shift_reg_if slave (controls, serial/parallel data, pulse)
// -----------------------------------------------------------------------------
module univ_shift_reg
    import shift_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    univ_shift_reg_if.slave     bus
);

    logic [WIDTH-1:0] q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (bus.en) begin
            case (bus.mode)
                MODE_SHR:  q <= {bus.ser_in_r, q[WIDTH-1:1]};
                MODE_SHL:  q <= {q[WIDTH-2:0], bus.ser_in_l};
                MODE_LOAD: q <= bus.par_in;
                default:   q <= q;
            endcase
        end
    end

    assign bus.par_out   = q;
    assign bus.ser_out_r = q[0];
    assign bus.ser_out_l = q[WIDTH-1];

    usr_word_framer #(
        .WIDTH (WIDTH)
    ) u_framer (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (bus.en),
        .mode       (bus.mode),
        .word_valid (bus.word_valid)
    );

endmodule : univ_shift_reg

// File: tb/tb_univ_shift_reg.sv
// -----------------------------------------------------------------------------
// tb_univ_shift_reg
// Self-checking bench for univ_shift_reg (WIDTH=4): directed scenarios
// followed by randomized operations, all compared against a reference model
// that tracks the register value and the length of the current word.
// -----------------------------------------------------------------------------
module tb_univ_shift_reg;

    localparam int WIDTH = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    int checks = 0;
    int passed = 0;
    int fails  = 0;

    // Reference model: register value, direction of the word in progress
    // (0 none, 1 right, 2 left), bits collected so far, expected pulse.
    logic [WIDTH-1:0] mq;
    int               mdir;
    int               mbits;
    logic             mwv;

    univ_shift_reg_if #(.WIDTH(WIDTH)) bus ();

    univ_shift_reg #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq    = '0;
        mdir  = 0;
        mbits = 0;
        mwv   = 1'b0;
    endtask

    // One shift count in direction d; a change of direction restarts the word.
    task automatic model_shift(input int d);
        if (mdir != d) begin
            mdir  = d;
            mbits = 1;
        end else begin
            mbits = mbits + 1;
        end
        if (mbits == WIDTH) begin
            mbits = 0;
            mwv   = 1'b1;
        end
    endtask

    // Drive one cycle of inputs, advance the model, sample #1 after the edge.
    task automatic step(input logic e, input logic [1:0] m, input logic sr,
                        input logic sl, input logic [WIDTH-1:0] pin);
        bus.en       = e;
        bus.mode     = m;
        bus.ser_in_r = sr;
        bus.ser_in_l = sl;
        bus.par_in   = pin;
        check("ser_out_r_pre", 32'(bus.ser_out_r), 32'(mq[0]));
        mwv = 1'b0;
        if (e) begin
            case (m)
                2'd1: begin
                    mq = WIDTH'(mq / 2 + (sr ? (1 << (WIDTH - 1)) : 0));
                    model_shift(1);
                end
                2'd2: begin
                    mq = WIDTH'(mq * 2 + sl);
                    model_shift(2);
                end
                2'd3: begin
                    mq    = pin;
                    mdir  = 0;
                    mbits = 0;
                end
                default: ;
            endcase
        end
        @(posedge clk);
        #1;
        check("par_out", 32'(bus.par_out), 32'(mq));
        check("word_valid", 32'(bus.word_valid), 32'(mwv));
        check("ser_out_r", 32'(bus.ser_out_r), 32'(mq[0]));
        check("ser_out_l", 32'(bus.ser_out_l), 32'(mq[WIDTH-1]));
    endtask

    // Assert reset between edges and check outputs clear before the next edge.
    task automatic async_reset();
        #3 rst_n = 1'b0;
        #1;
        model_reset();
        check("rst_par_out", 32'(bus.par_out), 32'(0));
        check("rst_word_valid", 32'(bus.word_valid), 32'(0));
        check("rst_ser_out_l", 32'(bus.ser_out_l), 32'(0));
        #2 rst_n = 1'b1;
    endtask

    initial begin
        logic [WIDTH-1:0] exp_shr [4];
        logic [WIDTH-1:0] exp_shl [4];
        logic [3:0]       bits_r;
        logic [3:0]       bits_l;
        logic [3:0]       piso;
        int               pulses;
        int               rdir;
        logic [1:0]       m;
        logic             e;

        exp_shr = '{4'b1000, 4'b0100, 4'b1010, 4'b0101};
        exp_shl = '{4'b0001, 4'b0011, 4'b0110, 4'b1101};
        bits_r  = 4'b0101;  // applied bit i = bits_r[i]: 1,0,1,0
        bits_l  = 4'b1011;  // applied bit i = bits_l[i]: 1,1,0,1

        bus.en       = 1'b0;
        bus.mode     = 2'd0;
        bus.ser_in_r = 1'b0;
        bus.ser_in_l = 1'b0;
        bus.par_in   = '0;
        model_reset();

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("reset_par_out", 32'(bus.par_out), 32'(0));
        check("reset_word_valid", 32'(bus.word_valid), 32'(0));
        check("reset_ser_out_r", 32'(bus.ser_out_r), 32'(0));
        check("reset_ser_out_l", 32'(bus.ser_out_l), 32'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Asynchronous reset after a load
        step(1'b1, 2'd3, 1'b0, 1'b0, 4'b1011);
        check("load_1011", 32'(bus.par_out), 32'(4'b1011));
        async_reset();

        // SIPO right
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 2'd1, bits_r[i], 1'b0, '0);
            check("shr_const", 32'(bus.par_out), 32'(exp_shr[i]));
            check("shr_pulse", 32'(bus.word_valid), 32'(i == 3));
        end

        // SIPO left
        step(1'b1, 2'd3, 1'b0, 1'b0, 4'b0000);
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 2'd2, 1'b0, bits_l[i], '0);
            check("shl_const", 32'(bus.par_out), 32'(exp_shl[i]));
            check("shl_pulse", 32'(bus.word_valid), 32'(i == 3));
        end

        // PISO: serial output read before each edge
        step(1'b1, 2'd3, 1'b0, 1'b0, 4'b1011);
        piso   = '0;
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            piso[i] = bus.ser_out_r;
            step(1'b1, 2'd1, 1'b0, 1'b0, '0);
            pulses += int'(bus.word_valid);
        end
        check("piso_bits", 32'(piso), 32'(4'b1011));
        check("piso_final", 32'(bus.par_out), 32'(0));
        check("piso_pulses", 32'(pulses), 32'(1));

        // Direction switch
        step(1'b1, 2'd3, 1'b0, 1'b0, 4'b0000);
        for (int i = 0; i < 6; i++) begin
            step(1'b1, (i < 2) ? 2'd1 : 2'd2, 1'b1, 1'b1, '0);
            check("switch_pulse", 32'(bus.word_valid), 32'(i == 5));
        end

        // Hold / enable
        step(1'b1, 2'd3, 1'b0, 1'b0, 4'b0000);
        pulses = 0;
        for (int i = 0; i < 9; i++) begin
            if (i < 2)      step(1'b1, 2'd1, 1'b1, 1'b0, '0);
            else if (i < 5) step(1'b1, 2'd0, 1'b1, 1'b1, 4'b1111);
            else if (i < 7) step(1'b0, 2'd1, 1'b1, 1'b1, 4'b1111);
            else            step(1'b1, 2'd1, 1'b0, 1'b0, '0);
            if (i >= 2 && i < 7) check("hold_frozen", 32'(bus.par_out), 32'(4'b1100));
            pulses += int'(bus.word_valid);
        end
        check("hold_final", 32'(bus.par_out), 32'(4'b0011));
        check("hold_pulses", 32'(pulses), 32'(1));

        // Reset mid-word loses the partial word
        step(1'b1, 2'd1, 1'b1, 1'b0, '0);
        step(1'b1, 2'd1, 1'b1, 1'b0, '0);
        async_reset();
        step(1'b1, 2'd1, 1'b1, 1'b0, '0);
        step(1'b1, 2'd1, 1'b1, 1'b0, '0);
        check("midword_no_pulse", 32'(bus.word_valid), 32'(0));

        // Randomized operation, biased toward runs in one direction
        rdir = 1;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 5) == 0) rdir = (rdir == 1) ? 2 : 1;
            case ($urandom_range(0, 9))
                0:       m = 2'd0;
                1:       m = 2'd3;
                default: m = 2'(rdir);
            endcase
            e = ($urandom_range(0, 7) != 0);
            step(e, m, 1'($urandom), 1'($urandom), WIDTH'($urandom));
            if (i % 97 == 96) async_reset();
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule : tb_univ_shift_reg

// File: doc/univ_shift_reg.md
# univ_shift_reg

Parametrised universal shift register: WIDTH-bit register with hold, shift-right, shift-left and parallel-load modes. Each direction has its own serial input and serial output, and the register is also readable in parallel. A word framer pulses `word_valid` after every WIDTH consecutive same-direction shifts, so the block can act as SISO, SIPO, PISO or PIPO. It is the generalised successor to the fixed 4-bit right-shift registers, and sits between serial links and word-wide datapaths.

## Interface
- `WIDTH`, 4: register width in bits. Must be ≥ 2.
- `CNT_W`, `$clog2(WIDTH)`: bit-counter width. Derived, not overridden.

- `clk`  in  1: rising-edge clock.
- `rst_n`  in  1: asynchronous, active-low reset. One clock; reset is asynchronous and active-low.
- `en`  in  1: clock enable. When 0, all state holds.
- `mode`  in  2: operation select. 00 HOLD, 01 SHR, 10 SHL, 11 LOAD.
- `ser_in_r`  in  1: serial input, enters the MSB on SHR.
- `ser_in_l`  in  1: serial input, enters the LSB on SHL.
- `par_in`  in  WIDTH: parallel load data.
- `par_out`  out  WIDTH: register contents.
- `ser_out_r`  out  1: `par_out[0]`, the right-shift serial output.
- `ser_out_l`  out  1: `par_out[WIDTH-1]`, the left-shift serial output.
- `word_valid`  out  1: one-cycle pulse when a full word has been shifted.

## Operation
- Register `q` behaviour per edge, with `en=1`:
  - HOLD: `q` unchanged.
  - SHR: `q <= {ser_in_r, q[WIDTH-1:1]}`.
  - SHL: `q <= {q[WIDTH-2:0], ser_in_l}`.
  - LOAD: `q <= par_in`.
- Direction FSM, states IDLE, RIGHT, LEFT:
  - Reset or LOAD → IDLE, with `cnt=0`.
  - SHR from IDLE or RIGHT → RIGHT, `cnt+1`.
  - SHL from IDLE or LEFT → LEFT, `cnt+1`.
  - SHR from LEFT, or SHL from RIGHT: switch state and set `cnt=1`. The switching shift counts as the first bit of a new word.
  - HOLD: state and `cnt` unchanged. Mid-word holds are allowed and do not break the word.
- Wrap-around: a shift taken while `cnt==WIDTH-1` sets `cnt=0` and sets `word_valid` for the next cycle. The FSM stays in its direction, so back-to-back words need no idle cycle.
- `en=0`: `q`, `cnt`, state all frozen; `word_valid` is 0 on the next cycle. `mode` and the data inputs are ignored.
- LOAD issued while `cnt≠0` discards the partial word; no pulse is produced.
- Counting is modulo WIDTH; no overflow beyond `WIDTH-1` is reachable.

## Timing
- Reset values, asserted asynchronously and immediately on `rst_n` falling: `par_out=0`, `ser_out_r=0`, `ser_out_l=0`, `word_valid=0`, `cnt=0`, FSM=IDLE.
- Reset release: the first active edge is the first rising `clk` after `rst_n` rises. The release is synchronised externally.
- `par_out`: registered, with 1-cycle latency from mode/data to output.
- `ser_out_r` and `ser_out_l`: combinational from `q`, with no extra latency.
- `word_valid`: registered. It is high for exactly one cycle, the cycle in which `par_out` first shows the completed word.
- `rst_n` asserted mid-word: the partial word is lost and no pulse follows.

## Structure
- Shared package `shift_pkg`:
  - `localparam`s `MODE_HOLD`, `MODE_SHR`, `MODE_SHL`, `MODE_LOAD` (2-bit).
  - Direction enum `dir_t` {`DIR_IDLE`, `DIR_RIGHT`, `DIR_LEFT`}.
- Sub-module `usr_word_framer`: holds the direction FSM, `cnt` and the `word_valid` register. Inputs are `clk`, `rst_n`, `en`, `mode`; output is `word_valid`. The top level holds only the `q` datapath mux.

## Test plan
All scenarios use `WIDTH=4`.
- Async reset: LOAD 4'b1011, then drop `rst_n` between edges → `par_out=0000` and `word_valid=0` before the next edge.
- SHR from 0000 with `ser_in_r` = 1,0,1,0 → `par_out` = 1000, 0100, 1010, 0101. `word_valid=1` only in the cycle showing 0101.
- SHL from 0000 with `ser_in_l` = 1,1,0,1 → `par_out` = 0001, 0011, 0110, 1101. `word_valid` pulses with 1101.
- LOAD 1011, then 4×SHR with `ser_in_r=0` → `ser_out_r` sampled before each edge reads 1,1,0,1. The final `par_out=0000`, and `word_valid` pulses once.
- Direction switch: SHR, SHR, SHL, SHL, SHL, SHL → no pulse after the SHRs; pulse only after the 4th SHL.
- Hold/enable: SHR×2, then HOLD×3, then `en=0` with `mode=SHR` for 2 cycles, then SHR×2 → `par_out` is frozen during hold/disable. The pulse arrives after the 4th effective SHR, and no extra pulse occurs.
